// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, H/V counters, sync and
// active decodes, frame-start strobe and a once-per-second tick. All outputs
// are registered from the next-state counts, so they stay aligned with
// Hcount/Vcount.
module vga_timing_gen #(
    parameter int CLK_DIV        = 4,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] Hcount,
    output logic [9:0] Vcount,
    output logic       Hsync,
    output logic       Vsync,
    output logic       active,
    output logic       pix_en,
    output logic       frame_start,
    output logic       sec
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST      = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0]       H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             pix_en_q, pix_en_d;
    logic             frame_start_q, frame_start_d;
    logic             sec_q, sec_d;
    logic             tick;
    logic             frame_wrap;

    // Next-state logic: divider, raster counters, decodes and frame/second tick.
    always_comb begin
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        frame_wrap = 1'b0;

        // Counters move on the divider terminal count, so the new count and
        // pix_en appear together one clk later. >= keeps counts in range even
        // if a state were ever corrupted.
        if (tick) begin
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                if (vcount_q >= V_LAST) begin
                    vcount_d   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        pix_en_d      = tick;
        hsync_d       = !((hcount_d >= H_SYNC_START) && (hcount_d < H_SYNC_END));
        vsync_d       = !((vcount_d >= V_SYNC_START) && (vcount_d < V_SYNC_END));
        active_d      = (hcount_d < H_ACT_END) && (vcount_d < V_ACT_END);
        frame_start_d = frame_wrap;

        // Frame counter only moves on real wraps, so the post-reset (0,0)
        // neither counts as a frame nor produces a sec tick.
        fcnt_d = fcnt_q;
        sec_d  = 1'b0;
        if (frame_wrap) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d = '0;
                sec_d  = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            fcnt_q        <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sec_q         <= 1'b0;
        end else begin
            div_q         <= div_d;
            fcnt_q        <= fcnt_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
            sec_q         <= sec_d;
        end
    end

    assign Hcount      = hcount_q;
    assign Vcount      = vcount_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign active      = active_q;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_q;
    assign sec         = sec_q;

endmodule
